uart_rx_core: RTL

//  UART receive engine for the APB UART. Consumes the 16x rx_sample_pulse from the baud

---
 rtl/uart_rx_core.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receive engine: recovers 8N1/8E1/8O1 frames from rxd using a 16x sample strobe
// and holds one byte with parity, framing and overrun status for the register block.
module uart_rx_core #(
   parameter int OVS         = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       PCLK,
   input  logic       PRESETN,
   input  logic       rx_sample_pulse,
   input  logic       rxd,
   input  logic       parity_en,
   input  logic       parity_odd,
   input  logic       rx_rd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overrun
);

   localparam int CW = $clog2(OVS);
   localparam logic [CW-1:0] S_PRE  = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] S_MID  = CW'(OVS / 2);
   localparam logic [CW-1:0] S_POST = CW'(OVS / 2 + 1);
   localparam logic [CW-1:0] S_LAST = CW'(OVS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic [CW-1:0]          scnt, scnt_nxt;
   logic [2:0]             bitcnt, bitcnt_nxt;
   logic [7:0]             shreg, shreg_nxt;
   logic [1:0]             vote, vote_nxt;
   logic                   par_bit, par_nxt;
   logic                   vote_bit;
   logic                   commit;
   logic                   perr_c;

   // Synchroniser resets to the idle-high line level so reset release cannot look like a start bit.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) sync_q <= '1;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end

   assign rxd_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state   <= IDLE;
         scnt    <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         vote    <= '0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_nxt;
         scnt    <= scnt_nxt;
         bitcnt  <= bitcnt_nxt;
         shreg   <= shreg_nxt;
         vote    <= vote_nxt;
         par_bit <= par_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      scnt_nxt   = scnt;
      bitcnt_nxt = bitcnt;
      shreg_nxt  = shreg;
      vote_nxt   = vote;
      par_nxt    = par_bit;
      commit     = 1'b0;
      // Two earlier samples plus the live one form the mid-bit majority vote.
      vote_bit   = (vote[0] & vote[1]) | (vote[0] & rxd_s) | (vote[1] & rxd_s);
      perr_c     = parity_en & (par_bit != (^shreg ^ parity_odd));

      if (rx_sample_pulse) begin
         if (state != IDLE && state != WAIT_IDLE) begin
            scnt_nxt = (scnt == S_LAST) ? '0 : scnt + CW'(1);
            if (scnt == S_PRE) vote_nxt[0] = rxd_s;
            if (scnt == S_MID) vote_nxt[1] = rxd_s;
         end

         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state_nxt = START;
                  scnt_nxt  = '0;
               end
            end
            START: begin
               if (scnt == S_POST && vote_bit) begin
                  state_nxt = IDLE;
                  scnt_nxt  = '0;
               end else if (scnt == S_LAST) begin
                  state_nxt  = DATA;
                  bitcnt_nxt = '0;
               end
            end
            DATA: begin
               if (scnt == S_POST) shreg_nxt = {vote_bit, shreg[7:1]};
               if (scnt == S_LAST) begin
                  bitcnt_nxt = bitcnt + 3'd1;
                  if (bitcnt == 3'd7) state_nxt = parity_en ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (scnt == S_POST) par_nxt = vote_bit;
               if (scnt == S_LAST) state_nxt = STOP;
            end
            STOP: begin
               // Leaving on the decision pulse lets the next start bit be caught after a short stop bit.
               if (scnt == S_POST) begin
                  commit    = 1'b1;
                  scnt_nxt  = '0;
                  state_nxt = vote_bit ? IDLE : WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // A read that coincides with a commit frees the holding register for the new byte.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else if (commit) begin
         if (!rx_valid || rx_rd) begin
            rx_data     <= shreg;
            parity_err  <= perr_c;
            framing_err <= ~vote_bit;
            rx_valid    <= 1'b1;
            if (rx_rd) overrun <= 1'b0;
         end else begin
            overrun <= 1'b1;
         end
      end else if (rx_rd) begin
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end
   end

endmodule
